// File: rtl/button_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_input_pkg
//  Purpose  : Shared press-FSM state encoding and the press counter width for
//             the debounced push-button front end.
//  Revision : 1.0 - initial release
// ============================================================================
package button_input_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] press_state_t;

    localparam press_state_t ST_IDLE        = 2'd0;
    localparam press_state_t ST_PRESSED     = 2'd1;
    localparam press_state_t ST_HELD        = 2'd2;
    localparam press_state_t ST_WAIT_SECOND = 2'd3;

    localparam int PRESS_COUNT_W = 8;

endpackage : button_input_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Polarity normalisation, 2-flop synchroniser and stability
//             counter for one raw button pin. level is registered; rise/fall
//             are single-cycle strobes valid in the cycle before level changes,
//             so the parent can register its event outputs alongside level.
//  Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_pressed;
    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;
    logic             accept;

    // 1 means "pressed" from here on, regardless of board wiring.
    assign pin_pressed = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin_pressed;
            sync_q2 <= sync_q1;
        end
    end

    // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept = (sync_q2 != level) && (stable_cnt == CNT_LAST);
    assign rise   = accept & ~level;
    assign fall   = accept &  level;

    // Stability counter and the debounced level it guards.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (sync_q2 == level) begin
            stable_cnt <= '0;
        end else if (accept) begin
            stable_cnt <= '0;
            level      <= ~level;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

endmodule : button_debounce
`default_nettype wire

// File: rtl/button_input.sv
`default_nettype none
// ============================================================================
//  Module   : button_input
//  Purpose  : Debounced push-button front end: press/release pulses, short vs
//             long press classification and a wrapping press counter.
//  Options  : BUTTON_INPUT_DOUBLE_CLICK_EN - adds WAIT_SECOND state and the
//             double_pulse output for double-click detection.
//  Revision : 1.0 - initial release
// ============================================================================
module button_input
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int LONG_CYCLES     = 48000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int DOUBLE_WINDOW   = 12000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_in,
    output logic                     btn_level,
    output logic                     press_pulse,
    output logic                     release_pulse,
    output logic                     short_pulse,
    output logic                     long_pulse,
    output logic [PRESS_COUNT_W-1:0] press_count
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
    ,
    output logic                     double_pulse
`endif
);

    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || DOUBLE_WINDOW < 1) begin : g_param_check
        $error("button_input: illegal DEBOUNCE_CYCLES/LONG_CYCLES/DOUBLE_WINDOW");
    end

    logic              deb_rise;
    logic              deb_fall;
    press_state_t      state;
    press_state_t      state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              short_set;
    logic              long_set;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .level  (btn_level),
        .rise   (deb_rise),
        .fall   (deb_fall)
    );

    // The hold timer reaches LONG_CYCLES on this edge.
    assign hold_done = (hold_cnt == HOLD_LAST);

`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
    localparam int WIN_W = $clog2(DOUBLE_WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DOUBLE_WINDOW - 1);

    logic             double_set;
    logic             second_click;
    logic [WIN_W-1:0] win_cnt;
    logic             win_done;

    assign win_done = (win_cnt == WIN_LAST);

    // Window timer counts cycles since the first short release; second_click
    // marks a press that consumed a pending first click.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt      <= '0;
            second_click <= 1'b0;
            double_pulse <= 1'b0;
        end else begin
            win_cnt      <= (state == ST_WAIT_SECOND) ? win_cnt + WIN_W'(1) : '0;
            double_pulse <= double_set;
            if (deb_rise && state == ST_IDLE) begin
                second_click <= 1'b0;
            end else if (deb_rise && state == ST_WAIT_SECOND) begin
                second_click <= 1'b1;
            end
        end
    end
`endif

    // Press FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Press FSM next-state logic; a release in the threshold cycle beats long.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (deb_rise) state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (deb_fall) begin
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
                    state_next = second_click ? ST_IDLE : ST_WAIT_SECOND;
`else
                    state_next = ST_IDLE;
`endif
                end else if (hold_done) begin
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (deb_fall) state_next = ST_IDLE;
            end
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
            ST_WAIT_SECOND: begin
                if (deb_rise)      state_next = ST_PRESSED;
                else if (win_done) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Press FSM output decode: which classification pulse fires next cycle.
    always_comb begin
        long_set  = (state == ST_PRESSED) && !deb_fall && hold_done;
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
        short_set  = (state == ST_WAIT_SECOND) && !deb_rise && win_done;
        double_set = (state == ST_PRESSED) && deb_fall && second_click;
`else
        short_set  = (state == ST_PRESSED) && deb_fall;
`endif
    end

    // Registered event outputs, press counter and saturating hold timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
            hold_cnt      <= '0;
        end else begin
            press_pulse   <= deb_rise;
            release_pulse <= deb_fall;
            short_pulse   <= short_set;
            long_pulse    <= long_set;
            if (deb_rise) begin
                press_count <= press_count + PRESS_COUNT_W'(1);
            end
            if (deb_rise) begin
                hold_cnt <= '0;
            end else if ((state == ST_PRESSED || state == ST_HELD) && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule : button_input
`default_nettype wire

// File: tb/tb_button_input.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_input
//  Purpose  : Self-checking bench for button_input with an event/timestamp
//             reference model, directed scenarios and random button activity.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_input;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int WIN  = 10;
    localparam int HMAX = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       btn_level, press_pulse, release_pulse, short_pulse, long_pulse;
    logic [7:0] press_count;
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
    logic       double_pulse;
`endif

    button_input #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (1),
        .DOUBLE_WINDOW   (WIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
        ,
        .double_pulse  (double_pulse)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (timestamps of edges) ----------------
    bit pin_at [HMAX];
    bit rst_at [HMAX];
    bit m_level, m_in_press, m_pending, m_second;
    int m_run, m_press_edge, m_rel_edge, m_count;
    bit e_press, e_release, e_short, e_long, e_double;

    always @(posedge clk) begin
        bit smp, flip;
        cyc++;
        pin_at[cyc % HMAX] = ~btn_in;
        rst_at[cyc % HMAX] = rst;
        {e_press, e_release, e_short, e_long, e_double} = '0;
        if (rst) begin
            m_level = 0; m_run = 0; m_in_press = 0; m_pending = 0; m_second = 0; m_count = 0;
        end else begin
            // The debouncer sees the pin two edges late, and zero while the
            // synchroniser is still flushing a reset.
            smp = (cyc >= 3 && !rst_at[(cyc-1) % HMAX] && !rst_at[(cyc-2) % HMAX])
                  ? pin_at[(cyc-2) % HMAX] : 1'b0;
            flip = 0;
            if (smp != m_level) begin
                m_run++;
                if (m_run == DEB) begin m_level = ~m_level; m_run = 0; flip = 1; end
            end else begin
                m_run = 0;
            end
            if (flip && m_level) begin
                e_press = 1; m_count = (m_count + 1) % 256; m_second = 0;
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
                if (m_pending && cyc - m_rel_edge <= WIN) m_second = 1;
                m_pending = 0;
`endif
                m_press_edge = cyc; m_in_press = 1;
            end else if (flip) begin
                e_release = 1; m_in_press = 0;
                if (cyc - m_press_edge <= LONG) begin
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
                    if (m_second) e_double = 1;
                    else begin m_pending = 1; m_rel_edge = cyc; end
`else
                    e_short = 1;
`endif
                end
            end
            if (m_in_press && cyc == m_press_edge + LONG) e_long = 1;
            if (m_pending && cyc == m_rel_edge + WIN) begin e_short = 1; m_pending = 0; end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("btn_level",     btn_level,     m_level);
            check("press_pulse",   press_pulse,   e_press);
            check("release_pulse", release_pulse, e_release);
            check("short_pulse",   short_pulse,   e_short);
            check("long_pulse",    long_pulse,    e_long);
            check("press_count",   press_count,   m_count);
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
            check("double_pulse",  double_pulse,  e_double);
`endif
        end
    end

    // ---------------- pulse monitor for the literal checks ----------------
    int n_press, n_release, n_short, n_long, n_double;
    int t_press, t_release, t_short, t_long;

    always @(negedge clk) begin
        if (press_pulse)   begin n_press++;   if (t_press   < 0) t_press   = cyc; end
        if (release_pulse) begin n_release++; if (t_release < 0) t_release = cyc; end
        if (short_pulse)   begin n_short++;   if (t_short   < 0) t_short   = cyc; end
        if (long_pulse)    begin n_long++;    if (t_long    < 0) t_long    = cyc; end
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
        if (double_pulse)  n_double++;
`endif
    end

    task automatic clear_seen();
        n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;
        t_press = -1; t_release = -1; t_short = -1; t_long = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Press for hold cycles, release, then idle long enough to settle.
    task automatic press_for(input int hold);
        clear_seen();
        btn_in = 1'b0; step(hold);
        btn_in = 1'b1; step(40);
    endtask

    initial begin
        int c0, r;
        clear_seen();

        // Reset state
        rst = 1'b1; btn_in = 1'b1; step(3);
        check("rst_level", btn_level, 0);
        check("rst_count", press_count, 0);
        check("rst_pulses", {press_pulse, release_pulse, short_pulse, long_pulse}, 0);
        rst = 1'b0; step(10);

        // Bounce, then a 10-cycle short press
        clear_seen();
        btn_in = 1'b0; step(2); btn_in = 1'b1; step(1);
        btn_in = 1'b0; c0 = cyc; step(10);
        btn_in = 1'b1; step(40);
        check("bounce_press_latency", t_press - c0, 6);
        check("bounce_count", press_count, 1);
        check("short_n_long", n_long, 0);
        check("short_n_short", n_short, 1);
`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
        check("short_after_window", t_short - t_release, 10);
`else
        check("short_with_release", t_short - t_release, 0);
`endif

        // Long press
        press_for(40);
        check("long_delay", t_long - t_press, 20);
        check("long_n_short", n_short, 0);
        check("long_n_release", n_release, 1);

        // Boundary: release lands on the threshold cycle -> short
        press_for(20);
        check("bnd_release_at_20", t_release - t_press, 20);
        check("bnd_n_long", n_long, 0);
        check("bnd_n_short", n_short, 1);

        // One cycle later -> long
        press_for(21);
        check("bnd21_n_long", n_long, 1);
        check("bnd21_n_short", n_short, 0);

`ifdef BUTTON_INPUT_DOUBLE_CLICK_EN
        // Two short presses 5 cycles apart
        clear_seen();
        btn_in = 1'b0; step(10); btn_in = 1'b1; step(5);
        btn_in = 1'b0; step(10); btn_in = 1'b1; step(40);
        check("dbl_n_double", n_double, 1);
        check("dbl_n_short", n_short, 0);
`endif

        // Reset held 3 cycles mid-press
        clear_seen();
        btn_in = 1'b0; step(10);
        rst = 1'b1; step(1);
        check("midrst_level", btn_level, 0);
        check("midrst_count", press_count, 0);
        step(2);
        rst = 1'b0; c0 = cyc; clear_seen(); step(12);
        check("midrst_press_latency", t_press - c0, 6);
        check("midrst_count_after", press_count, 1);
        btn_in = 1'b1; step(40);

        // Counter wrap from reset
        rst = 1'b1; step(2); rst = 1'b0; step(5);
        clear_seen();
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b0; step(5); btn_in = 1'b1; step(5);
        end
        step(30);
        check("wrap_n_press", n_press, 256);
        check("wrap_count", press_count, 0);

        // Random button activity with occasional resets
        while (cyc < 12000) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0;
            end else begin
                btn_in = ~btn_in;
                if (r < 40)      step($urandom_range(1, 4));
                else if (r < 85) step($urandom_range(5, 25));
                else             step($urandom_range(20, 40));
            end
        end
        btn_in = 1'b1; step(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_input
`default_nettype wire

// File: doc/button_input.md
# button_input

Debounced push-button front end for the iCE40 UltraPlus board designs; the input-side counterpart of the LED drivers. It synchronises one raw mechanical button, filters bounce with a stability counter, and classifies each press as short or long. Clean one-cycle event pulses and a wrapping press counter are delivered to the user logic. It runs on the SB_HFOSC-derived system clock, 48 MHz by default.

## Interface
- DEBOUNCE_CYCLES, 480000: consecutive stable synchronised samples needed to accept a level change (10 ms at 48 MHz); minimum 2.
- LONG_CYCLES, 48000000: held duration that makes a press long (1 s); must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed.
- DOUBLE_WINDOW, 12000000: max release-to-press gap for a double click (250 ms); used only with the macro.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  raw asynchronous button pin.
- btn_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one cycle, debounced press accepted.
- release_pulse  out  1  one cycle, debounced release accepted.
- short_pulse  out  1  one cycle, press ended before LONG_CYCLES.
- long_pulse  out  1  one cycle, press reached LONG_CYCLES.
- press_count  out  8  number of accepted presses, modulo 256.
- double_pulse  out  1  one cycle, double click; present only with the macro.

## Operation
- Polarity: btn_in is inverted when ACTIVE_LOW=1, then passes through a 2-flop synchroniser. The synchroniser flops reset to the released level.
- Debounce: a stability counter clears whenever the synchronised sample equals btn_level. It increments while the two differ. When the counter reaches DEBOUNCE_CYCLES, btn_level toggles and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- Event pulses: press_pulse and release_pulse assert in the first cycle of the new btn_level value. press_count increments in the same cycle as press_pulse and wraps 255 -> 0.
- Press FSM states:
  - IDLE -> PRESSED on press_pulse; the hold timer clears.
  - PRESSED -> HELD when the hold timer reaches LONG_CYCLES; long_pulse fires.
  - PRESSED -> IDLE on release_pulse; short_pulse fires in the same cycle.
  - HELD -> IDLE on release_pulse; no short_pulse.
- At most one of short_pulse and long_pulse fires per press.
- Hold timer width is $clog2(LONG_CYCLES+1). It saturates in HELD and never wraps.
- Reset mid-operation: every output, counter and FSM state returns to its reset value. A button held through reset is reported as a new press 2+DEBOUNCE_CYCLES cycles after rst drops.

## Timing
- Reset values: btn_level 0, all pulse outputs 0, press_count 0, FSM IDLE.
- Latency from a btn_in transition, stable from cycle 0, to btn_level/press_pulse: 2 + DEBOUNCE_CYCLES cycles.
- long_pulse asserts exactly LONG_CYCLES cycles after the press_pulse cycle.
- If release_pulse and the LONG_CYCLES threshold fall in the same cycle, the release wins: short_pulse fires and long_pulse does not.
- All outputs are registered. No combinational path exists from btn_in to any output.

## Configuration
- BUTTON_INPUT_DOUBLE_CLICK_EN defined:
  - A short release enters state WAIT_SECOND instead of emitting short_pulse.
  - A press within DOUBLE_WINDOW cycles of that release consumes the first click. If the second press releases short, double_pulse fires in place of short_pulse. If the second press becomes long, only long_pulse fires.
  - If the window expires first, short_pulse fires exactly DOUBLE_WINDOW cycles after the release cycle.
  - The double_pulse port exists.
- Macro undefined: no WAIT_SECOND state, no double_pulse port; short_pulse fires on release as described above.

## Structure
- Package button_input_pkg holds the FSM state encoding (IDLE, PRESSED, HELD, WAIT_SECOND) and the press_count width constant.
- Sub-module button_debounce holds the synchroniser, polarity inversion and stability counter. It outputs btn_level plus rise/fall strobes.
- The FSM, hold/window timers and counter stay in button_input.

## Test plan
All tests use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DOUBLE_WINDOW=10, ACTIVE_LOW=1.
- Bounce: btn_in low for 2 cycles, high 1, then low steady -> press_pulse exactly 6 cycles after the final low edge, press_count = 1.
- Short press: btn_in held low 10 cycles, then released -> release_pulse and short_pulse in the same cycle, no long_pulse.
- Long press: held 40 cycles -> long_pulse at press_pulse+20; on release, release_pulse only.
- Boundary: release timed so release_pulse lands on press_pulse+20 -> short_pulse, no long_pulse.
- Wrap: 256 clean presses -> press_count returns to 0.
- With BUTTON_INPUT_DOUBLE_CLICK_EN:
  - Two short presses 5 cycles apart -> one double_pulse, no short_pulse.
  - One short press -> short_pulse at release+10.
- Reset held 3 cycles mid-press -> all outputs 0; press_pulse 6 cycles after rst falls.
